// File: rtl/if_fetch_ctrl.sv
// Fetch-stage PC / instruction-request controller with redirect squash and one-entry skid.
// Optional perf counters enabled by defining IF_FETCH_PERF_EN.
module if_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_enable,
  input  logic [15:0] br_addr,
  input  logic [1:0]  pcmux_sel,
  input  logic        stall_in,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        imem_read,
  output logic [15:0] imem_address,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        flush,
  output logic [15:0] perf_redirects,
  output logic [15:0] perf_drops
);

  typedef enum logic [1:0] {RUN, DROP, FULL} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pc_q, skid_pc_d;

  logic        redirect;
  logic [15:0] target;

  assign redirect     = ((pcmux_sel == 2'b01) && branch_enable) || (pcmux_sel == 2'b10);
  assign target       = {br_addr[15:1], 1'b0};
  assign flush        = redirect;
  assign imem_read    = rst_n && (state_q != FULL);
  assign imem_address = req_addr_q;
  assign if_valid     = if_valid_q;
  assign if_instr     = if_instr_q;
  assign if_pc        = if_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    unique case (state_q)
      RUN: begin
        if (imem_resp) begin
          if (redirect) begin
            req_addr_d = target;
          end else if (!(if_valid_q && stall_in)) begin
            if_instr_d = imem_rdata;
            if_pc_d    = req_addr_q;
            if_valid_d = 1'b1;
            pc_d       = req_addr_q + PC_INC;
            req_addr_d = req_addr_q + PC_INC;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = req_addr_q;
            pc_d         = req_addr_q + PC_INC;
            state_d      = FULL;
          end
        end else if (redirect) begin
          state_d = DROP;
        end else if (if_valid_q && !stall_in) begin
          if_valid_d = 1'b0;
        end
      end
      DROP: begin
        // stale response is thrown away; resume from the newest PC (target if redirecting now)
        if (imem_resp) begin
          req_addr_d = redirect ? target : pc_q;
          state_d    = RUN;
        end
      end
      FULL: begin
        if (redirect) begin
          req_addr_d = target;
          state_d    = RUN;
        end else if (!stall_in) begin
          if_instr_d = skid_instr_q;
          if_pc_d    = skid_pc_q;
          if_valid_d = 1'b1;
          req_addr_d = pc_q;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    if (redirect) begin
      pc_d       = target;
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic        drop_evt;
  logic [15:0] perf_redir_q, perf_drop_q;

  assign drop_evt = ((state_q == DROP) && imem_resp)
                 || ((state_q == RUN) && imem_resp && redirect)
                 || ((state_q == FULL) && redirect);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redir_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (redirect && (perf_redir_q != '1)) perf_redir_q <= perf_redir_q + 16'd1;
      if (drop_evt && (perf_drop_q != '1))  perf_drop_q  <= perf_drop_q + 16'd1;
    end
  end

  assign perf_redirects = perf_redir_q;
  assign perf_drops     = perf_drop_q;
`else
  assign perf_redirects = '0;
  assign perf_drops     = '0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: per-cycle comparison against a transaction-level model plus directed literal checks.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_enable;
  logic [15:0] br_addr;
  logic [1:0]  pcmux_sel;
  logic        stall_in;
  logic        imem_resp;
  logic [15:0] imem_rdata;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        flush;
  logic [15:0] perf_redirects;
  logic [15:0] perf_drops;

  int unsigned errors = 0;
  int unsigned checks = 0;

  if_fetch_ctrl #(.RESET_PC(16'h0000), .PC_INC(16'd2)) dut (
    .clk(clk), .rst_n(rst_n), .branch_enable(branch_enable), .br_addr(br_addr),
    .pcmux_sel(pcmux_sel), .stall_in(stall_in), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .imem_read(imem_read), .imem_address(imem_address), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .flush(flush), .perf_redirects(perf_redirects), .perf_drops(perf_drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an outstanding request that is either wanted or to be discarded,
  // plus a queue that holds at most one instruction waiting behind a stalled decode.
  logic [15:0] m_pc, m_req, m_instr, m_ipc, m_redirs, m_drops;
  logic        m_valid, m_discard;
  logic [31:0] m_skid[$];

  function automatic logic is_redir();
    return ((pcmux_sel == 2'b01) && branch_enable) || (pcmux_sel == 2'b10);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 16'h0000; m_req = 16'h0000; m_instr = 16'h0; m_ipc = 16'h0;
      m_valid = 1'b0; m_discard = 1'b0; m_redirs = 16'h0; m_drops = 16'h0;
      m_skid.delete();
    end else begin
      logic        r;
      logic [15:0] tgt;
      r   = is_redir();
      tgt = br_addr & 16'hFFFE;
      if (m_skid.size() != 0) begin
        if (r) begin
          m_skid.delete();
          if (m_drops != 16'hFFFF) m_drops++;
          m_req = tgt;
        end else if (!stall_in) begin
          m_instr = m_skid[0][31:16];
          m_ipc   = m_skid[0][15:0];
          m_valid = 1'b1;
          m_skid.delete();
          m_req = m_pc;
        end
      end else if (m_discard) begin
        if (imem_resp) begin
          m_discard = 1'b0;
          if (m_drops != 16'hFFFF) m_drops++;
          m_req = r ? tgt : m_pc;
        end
      end else if (r) begin
        if (imem_resp) begin
          if (m_drops != 16'hFFFF) m_drops++;
          m_req = tgt;
        end else begin
          m_discard = 1'b1;
        end
      end else if (imem_resp) begin
        if (m_valid && stall_in) begin
          m_skid.push_back({imem_rdata, m_req});
        end else begin
          m_instr = imem_rdata; m_ipc = m_req; m_valid = 1'b1;
          m_req = m_req + 16'd2;
        end
        m_pc = m_ipc + 16'd2;
        if (m_skid.size() != 0) m_pc = m_skid[0][15:0] + 16'd2;
      end else if (m_valid && !stall_in) begin
        m_valid = 1'b0;
      end
      if (r) begin
        m_pc = tgt;
        m_valid = 1'b0;
        if (m_redirs != 16'hFFFF) m_redirs++;
      end
    end
  end

  always @(negedge clk) begin
    chk("imem_read", {15'd0, imem_read}, {15'd0, rst_n && (m_skid.size() == 0)});
    chk("imem_address", imem_address, m_req);
    chk("flush", {15'd0, flush}, {15'd0, is_redir()});
    chk("if_valid", {15'd0, if_valid}, {15'd0, m_valid});
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ipc);
`ifdef IF_FETCH_PERF_EN
    chk("perf_redirects", perf_redirects, m_redirs);
    chk("perf_drops", perf_drops, m_drops);
`else
    chk("perf_redirects", perf_redirects, 16'h0);
    chk("perf_drops", perf_drops, 16'h0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] sel, input logic be, input logic [15:0] br,
                     input logic st, input logic rsp, input logic [15:0] rd);
    pcmux_sel = sel; branch_enable = be; br_addr = br;
    stall_in = st; imem_resp = rsp; imem_rdata = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick(); tick();
    chk("rst_imem_read", {15'd0, imem_read}, 16'h0);
    chk("rst_if_valid", {15'd0, if_valid}, 16'h0);
    rst_n = 1'b1;

    // sequential fetch from reset, response every cycle
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imem_address, 16'(2 * i));
      drv(2'b00, 1'b0, 16'h0, 1'b0, 1'b1, 16'hC000 + 16'(i));
      tick();
      chk("seq_if_pc", if_pc, 16'(2 * i));
      chk("seq_if_instr", if_instr, 16'hC000 + 16'(i));
      chk("seq_if_valid", {15'd0, if_valid}, 16'h1);
    end

    // conditional branch not taken
    drv(2'b01, 1'b0, 16'h0123, 1'b0, 1'b1, 16'hC004);
    #1 chk("nt_flush", {15'd0, flush}, 16'h0);
    tick();
    chk("nt_if_pc", if_pc, 16'h0008);
    chk("nt_addr", imem_address, 16'h000A);

    // conditional branch taken with response in the same cycle
    drv(2'b01, 1'b1, 16'h0123, 1'b0, 1'b1, 16'hBAD0);
    #1 chk("br_flush", {15'd0, flush}, 16'h1);
    tick();
    drv(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    chk("br_if_valid", {15'd0, if_valid}, 16'h0);
    chk("br_addr", imem_address, 16'h0122);

    // jump to 0x0010 with response, then redirect to 0x0040 while 0x0010 is pending
    drv(2'b10, 1'b0, 16'h0010, 1'b0, 1'b1, 16'hBAD1);
    tick();
    chk("jmp_addr", imem_address, 16'h0010);
    drv(2'b10, 1'b0, 16'h0040, 1'b0, 1'b0, 16'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drv(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
      tick();
      chk("drop_hold_addr", imem_address, 16'h0010);
    end
    drv(2'b00, 1'b0, 16'h0, 1'b0, 1'b1, 16'hDEAD);
    tick();
    chk("drop_next_addr", imem_address, 16'h0040);
    chk("drop_if_valid", {15'd0, if_valid}, 16'h0);
    drv(2'b00, 1'b0, 16'h0, 1'b0, 1'b1, 16'h4040);
    tick();
    chk("post_drop_if_pc", if_pc, 16'h0040);
`ifdef IF_FETCH_PERF_EN
    chk("perf_drops_lit", perf_drops, 16'd3);
    chk("perf_redirects_lit", perf_redirects, 16'd3);
`endif

    // skid: stall with a live output while 0x0008 returns
    drv(2'b10, 1'b0, 16'h0006, 1'b0, 1'b1, 16'hBAD2);
    tick();
    drv(2'b00, 1'b0, 16'h0, 1'b0, 1'b1, 16'h6666);
    tick();
    chk("skid_pre_if_pc", if_pc, 16'h0006);
    drv(2'b00, 1'b0, 16'h0, 1'b1, 1'b1, 16'h8888);
    tick();
    chk("full_imem_read", {15'd0, imem_read}, 16'h0);
    chk("full_if_pc", if_pc, 16'h0006);
    drv(2'b00, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
    tick();
    drv(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();
    chk("unskid_if_pc", if_pc, 16'h0008);
    chk("unskid_if_instr", if_instr, 16'h8888);
    chk("unskid_addr", imem_address, 16'h000A);

    // redirect while FULL, then enter DROP and reset asynchronously
    drv(2'b00, 1'b0, 16'h0, 1'b1, 1'b1, 16'hAAAA);
    tick();
    drv(2'b10, 1'b0, 16'h0100, 1'b1, 1'b0, 16'h0);
    tick();
    chk("fullredir_addr", imem_address, 16'h0100);
    chk("fullredir_if_valid", {15'd0, if_valid}, 16'h0);
    drv(2'b10, 1'b0, 16'h0200, 1'b0, 1'b0, 16'h0);
    tick();
    drv(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_imem_read", {15'd0, imem_read}, 16'h0);
    chk("async_addr", imem_address, 16'h0000);
    chk("async_if_pc", if_pc, 16'h0000);
    chk("async_perf_drops", perf_drops, 16'h0000);
    tick(); tick();
    rst_n = 1'b1;

    // odd target is forced even; PC wraps past 0xFFFE
    drv(2'b10, 1'b0, 16'hFFFF, 1'b0, 1'b1, 16'hBAD3);
    tick();
    chk("wrap_addr", imem_address, 16'hFFFE);
    drv(2'b00, 1'b0, 16'h0, 1'b0, 1'b1, 16'hFEFE);
    tick();
    chk("wrap_if_pc", if_pc, 16'hFFFE);
    chk("wrap_next_addr", imem_address, 16'h0000);

    // mixed traffic, checked by the per-cycle model
    for (int i = 0; i < 60; i++) begin
      logic [1:0] s;
      s = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      drv(s, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 2) != 0), 16'($urandom));
      tick();
    end
    drv(2'b00, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Fetch-stage PC and instruction-request controller for the pipelined LC-3b core.
- Consumes the EX-stage branch-resolution outputs (branch_enable, br_addr, pcmux_sel) and issues instruction-memory reads.
- Presents fetched instructions to the IF/ID register through a valid/stall handshake.
- On a redirect it squashes wrong-path work: it drops the in-flight fetch and flushes younger pipeline stages.

Parameters:
- RESET_PC, 16'h0000: PC loaded on reset.
- PC_INC, 2: sequential PC increment in bytes.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- branch_enable  in  1  conditional-branch taken flag from EX branch resolution
- br_addr  in  16  redirect target from EX branch resolution
- pcmux_sel  in  2  00 sequential, 01 conditional branch (uses branch_enable), 10 unconditional (JMP/JSR/TRAP), 11 treated as 00
- stall_in  in  1  decode cannot accept this cycle
- imem_resp  in  1  instruction memory response strobe
- imem_rdata  in  16  instruction memory data
- imem_read  out  1  instruction read request
- imem_address  out  16  request address
- if_valid  out  1  if_instr/if_pc hold a live instruction
- if_instr  out  16  fetched instruction
- if_pc  out  16  address of if_instr
- flush  out  1  squash IF/ID and ID/EX at next edge
- perf_redirects  out  16  redirect count (see Optional Feature)
- perf_drops  out  16  discarded-response count (see Optional Feature)

Behaviour:
Clocking and reset
- Single clock; reset asynchronous, active-low; all flops reset when rst_n=0.
- Reset values: pc=RESET_PC, req_addr=RESET_PC, state=RUN, if_valid=0, if_instr=0, if_pc=0, skid empty, perf counters 0.
- imem_read=0 while rst_n=0; the first request is issued the cycle after release.

Redirect and flush
- redirect = (pcmux_sel==01 & branch_enable) | (pcmux_sel==10). This is combinational.
- target = {br_addr[15:1],1'b0}; bit 0 is forced low.
- flush = redirect, same cycle.
- On any redirect edge: if_valid<=0, pc<=target.
- Redirect has priority over stall_in and imem_resp.

Request protocol
- imem_address = req_addr. req_addr is stable while imem_read=1 and no resp.
- imem_read stays high until imem_resp.

FSM (states RUN, DROP, FULL)
- RUN: imem_read=1.
  - resp & redirect: discard data; req_addr<=target; stay RUN.
  - resp & !(if_valid & stall_in): if_instr<=rdata, if_pc<=req_addr, if_valid<=1, pc<=req_addr+PC_INC, req_addr<=req_addr+PC_INC.
  - resp & if_valid & stall_in: store rdata/req_addr in skid; pc<=req_addr+PC_INC; go to FULL.
  - !resp & redirect: go to DROP; req_addr unchanged.
  - !resp & !redirect: if if_valid & !stall_in, if_valid<=0.
- DROP: imem_read=1 at the stale req_addr.
  - On resp: discard; req_addr<=pc; go to RUN.
  - A further redirect in DROP only updates pc.
- FULL: imem_read=0.
  - !stall_in: skid moves to the output (if_valid=1); req_addr<=pc; go to RUN.
  - redirect: skid discarded; req_addr<=target; go to RUN.
- Consumption: decode takes the output on an edge with if_valid & !stall_in. The output then reloads or clears in that same edge.

Arithmetic
- PC add is 16-bit and wraps: 16'hFFFE+2 -> 16'h0000.

Throughput
- One instruction per cycle when imem_resp is returned in the request cycle.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- Defined:
  - perf_redirects increments on every redirect cycle.
  - perf_drops increments on each response discarded in DROP, each response discarded in RUN on the redirect-and-resp case, and each discarded skid entry.
  - Both counters saturate at 16'hFFFF.
- Undefined: no counter flops; both ports are tied to 0.

Test Plan:
- Reset release with RESET_PC=0 and resp every cycle -> imem_address 0,2,4,6; if_pc follows one cycle later; if_valid=1 from the second cycle.
- pcmux_sel=01, branch_enable=1, br_addr=16'h0123 with resp high -> flush=1 that cycle; if_valid=0 next; next imem_address=16'h0122.
- pcmux_sel=01, branch_enable=0 -> no flush, sequential fetch continues.
- Redirect to 16'h0040 while resp is pending for 0x0010, resp arriving 3 cycles later -> imem_address held at 0x0010 through DROP; data discarded; next request 0x0040; perf_drops=1 with the macro.
- stall_in=1 with if_valid=1, resp for 0x0008 -> FULL, imem_read=0; stall_in low -> if_pc=0x0008, next request 0x000A.
- Redirect in FULL, then rst_n asserted mid-DROP -> skid discarded; on reset everything returns to reset values and imem_read=0 immediately (asynchronous).
